// File: rtl/jk_excitation_driver_if.sv
// Target handshake plus the JK latch-bank drive/feedback signals for jk_excitation_driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             en_out;
  logic             done;
  logic             err;

  // master = control FSM plus latch bank side, slave = the driver
  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j_out, k_out, en_out, done, err
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j_out, k_out, en_out, done, err
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Computes J/K excitation to move an external JK latch bank to a target, strobes it and waits to settle.
// JK_VERIFY_EN adds the post-settle CHECK with retries and err; without it, err is tied low.
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3
) (
  input logic                   clk,
  input logic                   rst,
  jk_excitation_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  localparam int CW = $clog2(SETTLE_CYC + 1) + 1;
`ifdef JK_VERIFY_EN
  localparam int SETTLE_LOAD = SETTLE_CYC - 1;
  localparam int RW          = $clog2(MAX_RETRY + 1) + 1;
`else
  // One extra settle cycle stands in for CHECK so latency matches the verify build
  localparam int SETTLE_LOAD = SETTLE_CYC;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             en_q, en_d, done_q, done_d, rdy_q, rdy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef JK_VERIFY_EN
  logic             err_q, err_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef JK_VERIFY_EN
    err_d   = err_q;
    retry_d = retry_q;
    tgt_d   = tgt_q;
`endif
    case (state_q)
      IDLE: if (bus.tgt_valid) begin
`ifdef JK_VERIFY_EN
        tgt_d   = bus.tgt_data;
        err_d   = 1'b0;
        retry_d = '0;
`endif
        if (bus.tgt_data == bus.q_fb) begin
          done_d = 1'b1;
        end else begin
          // set only bits rising, reset only bits falling: J and K never both high
          state_d = DRIVE;
          j_d     = ~bus.q_fb & bus.tgt_data;
          k_d     = bus.q_fb & ~bus.tgt_data;
          en_d    = 1'b1;
        end
      end
      DRIVE: begin
        state_d = SETTLE;
        cnt_d   = CW'(SETTLE_LOAD);
      end
      SETTLE: if (cnt_q == '0) begin
`ifdef JK_VERIFY_EN
        state_d = CHECK;
`else
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      CHECK: begin
`ifdef JK_VERIFY_EN
        if (bus.q_fb == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
          j_d     = ~bus.q_fb & tgt_q;
          k_d     = bus.q_fb & ~tgt_q;
          en_d    = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
`ifdef JK_VERIFY_EN
      err_q   <= 1'b0;
      retry_q <= '0;
      tgt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      en_q    <= en_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
`ifdef JK_VERIFY_EN
      err_q   <= err_d;
      retry_q <= retry_d;
      tgt_q   <= tgt_d;
`endif
    end
  end

  assign bus.j_out     = j_q;
  assign bus.k_out     = k_q;
  assign bus.en_out    = en_q;
  assign bus.done      = done_q;
  assign bus.tgt_ready = rdy_q;
`ifdef JK_VERIFY_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed table-driven bench for jk_excitation_driver with a behavioural JK latch-bank model.
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int MR = 3;
`ifdef JK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LAT = 2 + S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  jk_excitation_driver_if #(.WIDTH(W)) bus ();

  jk_excitation_driver #(.WIDTH(W), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // latch bank: on an enable strobe, J sets and K clears; stuck freezes the bank
  always @(posedge clk)
    if (!rst && bus.en_out && !stuck)
      bus.q_fb <= (bus.q_fb & ~bus.k_out) | bus.j_out;

  typedef struct {
    logic [W-1:0] q0;
    logic [W-1:0] tgt;
    logic [W-1:0] exp_j;
    logic [W-1:0] exp_k;
    bit           stk;
    int           pulses;
    bit           exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // caller is at a negedge; returns at a negedge one cycle after done
  task automatic run_vec(input vec_t v, input int idx);
    int  n, pulses, dn;
    bit  excl_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    stuck         = v.stk;
    bus.q_fb      = v.q0;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = v.tgt;
    @(posedge clk);
    #1 bus.tgt_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_j"}, 32'(bus.j_out), 32'(v.exp_j));
    chk({tag, "_k"}, 32'(bus.k_out), 32'(v.exp_k));
    chk({tag, "_en"}, 32'(bus.en_out), 32'd1);
    chk({tag, "_err_clr"}, 32'(bus.err), 32'd0);
    chk({tag, "_rdy_busy"}, 32'(bus.tgt_ready), 32'd0);
    n = 1; pulses = 0; dn = 0; excl_ok = 1'b1;
    while (dn == 0 && n < 60) begin
      if ((bus.j_out & bus.k_out) != '0) excl_ok = 1'b0;
      if (bus.en_out) pulses++;
      if (bus.done) dn = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_done_seen"}, 32'(dn != 0), 32'd1);
    chk({tag, "_pulses"}, 32'(pulses), 32'(v.pulses));
    chk({tag, "_latency"}, 32'(dn - 1), 32'(LAT * v.pulses));
    chk({tag, "_err"}, 32'(bus.err), 32'(v.exp_err));
    chk({tag, "_jk_excl"}, 32'(excl_ok), 32'd1);
    chk({tag, "_rdy_idle"}, 32'(bus.tgt_ready), 32'd1);
    if (!v.stk) chk({tag, "_qfb"}, 32'(bus.q_fb), 32'(v.tgt));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    stuck = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   pulses;
    bit   stay_low;
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1, 1'b0};
    vecs[1] = '{4'b1100, 4'b1010, 4'b0010, 4'b0100, 1'b0, 1, 1'b0};
    vecs[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1, 1'b0};
    vecs[3] = '{4'b0101, 4'b1010, 4'b1010, 4'b0101, 1'b0, 1, 1'b0};
    vecs[4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, VER ? 1 + MR : 1, VER};
    vecs[5] = '{4'b0011, 4'b0110, 4'b0100, 4'b0001, 1'b0, 1, 1'b0};

    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    bus.q_fb      = '0;
    #12;
    chk("rst_j", 32'(bus.j_out), 32'd0);
    chk("rst_k", 32'(bus.k_out), 32'd0);
    chk("rst_en", 32'(bus.en_out), 32'd0);
    chk("rst_rdy", 32'(bus.tgt_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // no-change shortcut: done next cycle, no strobe, stays ready
    bus.q_fb      = 4'b0110;
    bus.tgt_data  = 4'b0110;
    bus.tgt_valid = 1'b1;
    @(posedge clk);
    #1 bus.tgt_valid = 1'b0;
    @(negedge clk);
    chk("nochg_done", 32'(bus.done), 32'd1);
    chk("nochg_en", 32'(bus.en_out), 32'd0);
    chk("nochg_rdy", 32'(bus.tgt_ready), 32'd1);
    @(negedge clk);
    chk("nochg_done_1cyc", 32'(bus.done), 32'd0);
    chk("nochg_en2", 32'(bus.en_out), 32'd0);
    chk("nochg_rdy2", 32'(bus.tgt_ready), 32'd1);

    // target offered while busy is ignored
    bus.q_fb      = 4'b0000;
    bus.tgt_data  = 4'b0011;
    bus.tgt_valid = 1'b1;
    @(posedge clk);
    #1 bus.tgt_valid = 1'b0;
    @(negedge clk);
    chk("busy_j_drive", 32'(bus.j_out), 32'b0011);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1111;
    @(negedge clk);
    chk("busy_rdy", 32'(bus.tgt_ready), 32'd0);
    chk("busy_j_settle", 32'(bus.j_out), 32'd0);
    chk("busy_en_settle", 32'(bus.en_out), 32'd0);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    pulses = 0;
    for (int n = 3; n <= LAT + 1; n++) begin
      if (bus.en_out) pulses++;
      if (n < LAT + 1) @(negedge clk);
    end
    chk("busy_done", 32'(bus.done), 32'd1);
    chk("busy_err", 32'(bus.err), 32'd0);
    chk("busy_extra_pulses", 32'(pulses), 32'd0);
    chk("busy_qfb", 32'(bus.q_fb), 32'b0011);
    stay_low = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.en_out || bus.done) stay_low = 1'b0;
    end
    chk("busy_no_second_req", 32'(stay_low), 32'd1);

    // async reset in the middle of SETTLE
    bus.q_fb      = 4'b0000;
    bus.tgt_data  = 4'b1001;
    bus.tgt_valid = 1'b1;
    @(posedge clk);
    #1 bus.tgt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rdy_pre", 32'(bus.tgt_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_j", 32'(bus.j_out), 32'd0);
    chk("mid_rst_k", 32'(bus.k_out), 32'd0);
    chk("mid_rst_en", 32'(bus.en_out), 32'd0);
    chk("mid_rst_rdy", 32'(bus.tgt_ready), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[2], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
